// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: tracker entry layout,
// forwarding modes and stage indices.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned FWD_NONE     = 0;
  localparam int unsigned FWD_LOAD_USE = 1;

  localparam int unsigned STG_EXE = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  // Entry layout, MSB first: {valid, wb_en, mem_read, dest[reg_w-1:0]}
  localparam int unsigned ENT_FLAG_W = 3;

  function automatic int unsigned ent_w(input int unsigned reg_w);
    return reg_w + ENT_FLAG_W;
  endfunction

  function automatic int unsigned ent_valid_pos(input int unsigned reg_w);
    return reg_w + 2;
  endfunction

  function automatic int unsigned ent_wb_en_pos(input int unsigned reg_w);
    return reg_w + 1;
  endfunction

  function automatic int unsigned ent_mem_read_pos(input int unsigned reg_w);
    return reg_w;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// RAW comparator: flags when one in-flight entry writes a register that the
// instruction in ID reads.
module hazard_cmp #(
  parameter int unsigned REG_W = 4
) (
  input  logic             ent_valid,
  input  logic             ent_wb_en,
  input  logic [REG_W-1:0] ent_dest,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  output logic             match
);

  assign match = ent_valid && ent_wb_en &&
                 ((ent_dest == id_src1) || (id_two_src && (ent_dest == id_src2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flow controller: in-flight destination tracker, RAW stall
// detection, branch flush, memory hold and saturating performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STAGES  = 3,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned FORWARD = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_src1,
  input  logic [REG_W-1:0]  id_src2,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              freeze,
  output logic              flush,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned EW = ent_w(REG_W);
  localparam int unsigned VP = ent_valid_pos(REG_W);
  localparam int unsigned WP = ent_wb_en_pos(REG_W);
  localparam int unsigned MP = ent_mem_read_pos(REG_W);

  typedef logic [EW-1:0] ent_t;

  ent_t [STAGES-1:0] trk_q, trk_d;
  ent_t              id_ent, shift_in;
  logic [STAGES-2:0] match;
  logic              hazard;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  assign id_ent = {id_valid, id_wb_en, id_mem_read, id_dest};

  // The WB entry is left out of the window: the register file writes before ID reads.
  for (genvar i = STG_EXE; i < STAGES - 1; i++) begin : g_cmp
    hazard_cmp #(.REG_W(REG_W)) u_cmp (
      .ent_valid  (trk_q[i][VP]),
      .ent_wb_en  (trk_q[i][WP]),
      .ent_dest   (trk_q[i][REG_W-1:0]),
      .id_src1    (id_src1),
      .id_src2    (id_src2),
      .id_two_src (id_two_src),
      .match      (match[i])
    );
  end

  always_comb begin
    if (FORWARD == FWD_LOAD_USE) begin
      hazard = id_valid && match[STG_EXE] && trk_q[STG_EXE][MP];
    end else begin
      hazard = id_valid && (|match);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    freeze   = 1'b0;
    flush    = 1'b0;
    shift_in = id_ent;
    trk_d    = trk_q;
    if (mem_busy) begin
      freeze = 1'b1;
    end else begin
      if (branch_taken) begin
        flush    = 1'b1;
        shift_in = '0;
      end else if (hazard) begin
        freeze   = 1'b1;
        shift_in = '0;
      end else if (!id_valid) begin
        shift_in = '0;
      end
      trk_d = {trk_q[STAGES-2:0], shift_in};
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush  && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      trk_q       <= trk_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stage_valid = '0;
    for (int i = 0; i < int'(STAGES); i++) stage_valid[i] = trk_q[i][VP];
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Fields such as the WB entry's dest are carried for visibility but never read.
  logic unused_bits;
  assign unused_bits = ^{trk_q, 1'(STG_MEM), 1'(STG_WB)};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: three controller configurations share one stimulus stream
// and are compared every cycle against a behavioural pipeline model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_two_src, id_wb_en, id_mem_read, branch_taken, mem_busy;
  logic [3:0] id_src1, id_src2, id_dest;

  // Index 0: FORWARD=0, 1: FORWARD=1, 2: FORWARD=0 with CNT_W=2
  logic [2:0]       frz, fls;
  logic [2:0][2:0]  sv;
  logic [2:0][15:0] sc, fc;
  logic [1:0]       sat_sc, sat_fc;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.STAGES(3), .REG_W(4), .FORWARD(0), .CNT_W(16)) u_f0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .freeze(frz[0]), .flush(fls[0]), .stage_valid(sv[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0]));

  pipe_hazard_ctrl #(.STAGES(3), .REG_W(4), .FORWARD(1), .CNT_W(16)) u_f1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .freeze(frz[1]), .flush(fls[1]), .stage_valid(sv[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1]));

  pipe_hazard_ctrl #(.STAGES(3), .REG_W(4), .FORWARD(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .freeze(frz[2]), .flush(fls[2]), .stage_valid(sv[2]), .stall_cnt(sat_sc), .flush_cnt(sat_fc));

  assign sc[2] = {14'd0, sat_sc};
  assign fc[2] = {14'd0, sat_fc};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each configuration keeps a list of in-flight instructions indexed by age
  // (0 = one cycle after issue); younger entries age by one slot per moving cycle.
  typedef struct packed { bit v; bit w; bit m; bit [3:0] d; } inst_t;
  inst_t       mp   [3][3];
  int unsigned m_scnt [3];
  int unsigned m_fcnt [3];

  function automatic int unsigned cnt_max(input int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic bit reads_reg(input inst_t e);
    return e.v && e.w && (e.d == id_src1 || (id_two_src && e.d == id_src2));
  endfunction

  function automatic bit exp_hazard(input int k);
    if (!id_valid) return 1'b0;
    if (k == 1) return reads_reg(mp[k][0]) && mp[k][0].m;
    return reads_reg(mp[k][0]) || reads_reg(mp[k][1]);
  endfunction

  function automatic bit exp_freeze(input int k);
    return mem_busy || (!branch_taken && exp_hazard(k));
  endfunction

  function automatic bit exp_flush(input int k);
    return !mem_busy && branch_taken;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        for (int a = 0; a < 3; a++) mp[k][a] <= '0;
        m_scnt[k] <= 0;
        m_fcnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!mem_busy) begin
          mp[k][2] <= mp[k][1];
          mp[k][1] <= mp[k][0];
          if (branch_taken || exp_hazard(k) || !id_valid) mp[k][0] <= '0;
          else mp[k][0] <= {1'b1, id_wb_en, id_mem_read, id_dest};
        end
        if (exp_freeze(k) && m_scnt[k] < cnt_max(k)) m_scnt[k] <= m_scnt[k] + 1;
        if (exp_flush(k)  && m_fcnt[k] < cnt_max(k)) m_fcnt[k] <= m_fcnt[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("u%0d.freeze", k), 32'(frz[k]), 32'(exp_freeze(k)));
        check($sformatf("u%0d.flush", k), 32'(fls[k]), 32'(exp_flush(k)));
        check($sformatf("u%0d.stage_valid", k), 32'(sv[k]),
              32'({mp[k][2].v, mp[k][1].v, mp[k][0].v}));
        check($sformatf("u%0d.stall_cnt", k), 32'(sc[k]), m_scnt[k]);
        check($sformatf("u%0d.flush_cnt", k), 32'(fc[k]), m_fcnt[k]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    id_wb_en = 0; id_mem_read = 0; id_dest = 0;
    branch_taken = 0; mem_busy = 0;
  endtask

  task automatic issue(input logic [3:0] dest, input logic mr);
    idle();
    id_valid = 1; id_wb_en = 1; id_mem_read = mr; id_dest = dest;
  endtask

  task automatic consume(input logic [3:0] s1, input logic [3:0] s2, input logic two);
    idle();
    id_valid = 1; id_src1 = s1; id_src2 = s2; id_two_src = two;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 1'b1;
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset.stage_valid", 32'(sv[0]), 32'd0);
    check("reset.stall_cnt", 32'(sc[0]), 32'd0);
    next_cyc();

    // Dependent instruction, FORWARD=0: two freeze cycles
    issue(4'd3, 1'b0);                 next_cyc();
    consume(4'd3, 4'd0, 1'b0);
    @(negedge clk);
    check("dep.freeze_c1", 32'(frz[0]), 32'd1);
    check("dep.fwd_alu_no_freeze", 32'(frz[1]), 32'd0);
    next_cyc();
    @(negedge clk);
    check("dep.freeze_c2", 32'(frz[0]), 32'd1);
    next_cyc();
    @(negedge clk);
    check("dep.freeze_c3", 32'(frz[0]), 32'd0);
    next_cyc();
    idle();
    @(negedge clk);
    check("dep.stage_valid_c4", 32'(sv[0]), 32'b001);
    check("dep.stall_cnt", 32'(sc[0]), 32'd2);
    next_cyc();

    // Load-use with FORWARD=1: exactly one freeze
    do_reset();
    issue(4'd5, 1'b1);                 next_cyc();
    consume(4'd0, 4'd5, 1'b1);
    @(negedge clk);
    check("ldu.freeze_c1", 32'(frz[1]), 32'd1);
    next_cyc();
    @(negedge clk);
    check("ldu.freeze_c2", 32'(frz[1]), 32'd0);
    next_cyc();
    idle();
    @(negedge clk);
    check("ldu.stall_cnt", 32'(sc[1]), 32'd1);
    next_cyc();

    // Unread src2 and non-writing producer are not hazards
    do_reset();
    issue(4'd7, 1'b0);                 next_cyc();
    consume(4'd0, 4'd7, 1'b0);
    @(negedge clk);
    check("nohaz.src2_unread", 32'(frz[0]), 32'd0);
    next_cyc();
    idle(); id_valid = 1; id_dest = 4'd1; next_cyc();
    consume(4'd1, 4'd0, 1'b0);
    @(negedge clk);
    check("nohaz.wb_en0", 32'(frz[0]), 32'd0);
    next_cyc();

    // Taken branch beats a hazard in ID
    do_reset();
    issue(4'd3, 1'b0);                 next_cyc();
    consume(4'd3, 4'd0, 1'b0);
    branch_taken = 1;
    @(negedge clk);
    check("br.flush", 32'(fls[0]), 32'd1);
    check("br.freeze", 32'(frz[0]), 32'd0);
    next_cyc();
    idle();
    @(negedge clk);
    check("br.entry0_bubble", 32'(sv[0][0]), 32'd0);
    check("br.flush_cnt", 32'(fc[0]), 32'd1);
    check("br.stall_cnt", 32'(sc[0]), 32'd0);
    next_cyc();

    // Memory hold with a pending branch
    do_reset();
    issue(4'd9, 1'b0);                 next_cyc();
    issue(4'd10, 1'b0);                next_cyc();
    for (int c = 0; c < 3; c++) begin
      idle(); mem_busy = 1; branch_taken = 1;
      @(negedge clk);
      check("mb.freeze", 32'(frz[0]), 32'd1);
      check("mb.flush", 32'(fls[0]), 32'd0);
      check("mb.stage_valid", 32'(sv[0]), 32'b011);
      next_cyc();
    end
    idle(); branch_taken = 1;
    @(negedge clk);
    check("mb.flush_after", 32'(fls[0]), 32'd1);
    check("mb.stall_cnt", 32'(sc[0]), 32'd3);
    next_cyc();
    idle();

    // Asynchronous reset in the middle of a hazard stall
    do_reset();
    issue(4'd3, 1'b0);                 next_cyc();
    consume(4'd3, 4'd0, 1'b0);         next_cyc();
    @(negedge clk);
    check("arst.pre_freeze", 32'(frz[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst.stage_valid", 32'(sv[0]), 32'd0);
    check("arst.stall_cnt", 32'(sc[0]), 32'd0);
    check("arst.freeze", 32'(frz[0]), 32'd0);
    next_cyc();
    rst = 1'b0;
    idle();

    // Saturation of a 2-bit counter
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle(); mem_busy = 1; next_cyc();
    end
    idle();
    @(negedge clk);
    check("sat.stall_cnt", 32'(sc[2]), 32'd3);
    check("sat.wide_stall_cnt", 32'(sc[0]), 32'd5);
    next_cyc();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_src1      = 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      id_two_src   = 1'($urandom_range(0, 1));
      id_wb_en     = ($urandom_range(0, 3) != 0);
      id_mem_read  = 1'($urandom_range(0, 1));
      id_dest      = 4'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 9) == 0);
      mem_busy     = ($urandom_range(0, 9) == 0);
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      next_cyc();
    end
    idle();
    next_cyc();
    @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
